// File: rtl/decoder_addr_seq.sv
// Address stepper driving the 3-to-8 decoder selects {a,b,c}, with up/down, single/continuous scans and a per-address dwell.
// Optional skip mask enabled by defining DECODER_ADDR_SEQ_SKIP_MASK_EN.
module decoder_addr_seq #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       up_dn,
    input  logic       mode,
`ifdef DECODER_ADDR_SEQ_SKIP_MASK_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       step
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [2:0]       addr;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             wrap;
    logic [7:0]       mask;
    logic [7:0]       mask_q;

`ifdef DECODER_ADDR_SEQ_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask   = 8'h00;
    assign mask_q = 8'h00;
`endif

    assign {a, b, c} = addr;

    // First unmasked address at the start end of the scan.
    function automatic logic [2:0] first_addr(input logic d, input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d && !m[7-i]) r = 3'(7 - i);
            if (!d && !m[i])  r = 3'(i);
        end
        return r;
    endfunction

    // True when no unmasked address remains beyond cur in the scan direction.
    function automatic logic is_last(input logic [2:0] cur, input logic d, input logic [7:0] m);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 8; i++)
            if (!m[i] && (d ? (3'(i) > cur) : (3'(i) < cur))) r = 1'b0;
        return r;
    endfunction

    // Nearest unmasked address in the scan direction, modulo 8.
    function automatic logic [2:0] next_addr(input logic [2:0] cur, input logic d, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] cand;
        r = cur;
        for (int k = 7; k >= 1; k--) begin
            cand = d ? cur + 3'(k) : cur - 3'(k);
            if (!m[cand]) r = cand;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= 3'd0;
            cnt   <= '0;
            dir   <= 1'b0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            step  <= 1'b0;
`ifdef DECODER_ADDR_SEQ_SKIP_MASK_EN
            mask_q <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        dir  <= up_dn;
                        wrap <= mode;
                        cnt  <= '0;
`ifdef DECODER_ADDR_SEQ_SKIP_MASK_EN
                        mask_q <= mask;
`endif
                        if (&mask) begin
                            // nothing to visit: report completion straight away
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DWELL;
                            busy  <= 1'b1;
                            addr  <= first_addr(up_dn, mask);
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == TERM) begin
                        cnt <= '0;
                        if (is_last(addr, dir, mask_q) && !wrap) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            addr <= next_addr(addr, dir, mask_q);
                            step <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
